sram_port_arb: RTL and testbench
================================

SRAM_PORT_ARB -- requirements
Module: sram_port_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, number of requesters sharing SRAM port 0.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, SRAM word address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, SRAM word width.
REQ-004 SHALL have parameter NUM_WMASKS, default 4, byte-lane write-mask width (DATA_WIDTH/8).
REQ-005 SHALL have ports: clk  in  1  single clock; all logic on posedge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 req_valid  in  NUM_REQ  per-requester command valid.
REQ-008 req_ready  out  NUM_REQ  per-requester command accepted this cycle.
REQ-009 req_we  in  NUM_REQ  1=write, 0=read.
REQ-010 req_wmask  in  NUM_REQ*NUM_WMASKS  per-requester byte enables.
REQ-011 req_addr  in  NUM_REQ*ADDR_WIDTH  per-requester address.
REQ-012 req_wdata  in  NUM_REQ*DATA_WIDTH  per-requester write data.
REQ-013 rsp_valid  out  NUM_REQ  one-cycle read-data strobe to the issuing requester.
REQ-014 rsp_rdata  out  DATA_WIDTH  read data, shared, qualified by rsp_valid.
REQ-015 sram_csb0, sram_web0  out  1 each  active-low select / write enable to SRAM port 0.
REQ-016 sram_wmask0  out  NUM_WMASKS; sram_addr0  out  ADDR_WIDTH; sram_din0  out  DATA_WIDTH.
REQ-017 sram_dout0  in  DATA_WIDTH  SRAM port-0 read data.

Function
REQ-018 Command accepted on posedge where req_valid[i] && req_ready[i]; at most one req_ready bit high per cycle.
REQ-019 req_ready SHALL be combinational from req_valid and round-robin pointer; ready never asserted without valid.
REQ-020 Round-robin: priority starts at (last_granted+1) mod NUM_REQ; pointer updates only on acceptance.
REQ-021 Any requester holding valid SHALL be granted within NUM_REQ cycles.
REQ-022 On acceptance at edge t, SRAM outputs SHALL be registered at t: csb0=0, web0=~we, addr0, din0, wmask0 (wmask0=0 for reads).
REQ-023 Cycle with no acceptance: csb0=1, web0=1, wmask0=0; addr0/din0 hold previous value.
REQ-024 Throughput: one command per cycle, back-to-back, no bubbles, mixed read/write.
REQ-025 Read latency: rsp_valid[i] high for exactly the cycle following edge t+2; rsp_rdata = sram_dout0 registered at edge t+2.
REQ-026 Read tracking: 2-stage shift register of {valid, requester index}; writes insert valid=0.
REQ-027 Responses SHALL return in issue order; no response backpressure.
REQ-028 Write then read same address on consecutive edges SHALL return the new data (SRAM writes on negedge before read capture).
REQ-029 Write generates no response.

Reset
REQ-030 While rst high: req_ready=0, rsp_valid=0, rsp_rdata=0, csb0=1, web0=1, wmask0=0, addr0=0, din0=0, pointer=NUM_REQ-1 (requester 0 highest first).
REQ-031 Reset mid-operation SHALL discard in-flight reads; no rsp_valid after deassertion for pre-reset commands.
REQ-032 First acceptance possible on first posedge after rst deasserts.

Structure
REQ-033 Package sram_arb_pkg SHALL hold default width constants and READ_LAT=2.
REQ-034 Sub-module rr_arbiter (NUM_REQ, combinational grant + registered pointer) SHALL implement REQ-019..021.
REQ-035 Target size 120-400 RTL lines; no memory inside the block.

Verification
REQ-036 Single read: req0 read addr 0x10 (mem=0xDEADBEEF) -> csb0=0 one cycle, rsp_valid[0] 2 edges later, rdata=0xDEADBEEF.
REQ-037 Contention: both valid continuously, reads -> grants alternate 0,1,0,1; responses alternate matching index.
REQ-038 Masked write: req1 write addr 0x20 wdata 0x11223344 wmask 0b0101 over 0xFFFFFFFF -> readback 0xFF22FF44.
REQ-039 RAW: write 0xA5A5A5A5 to 0x05 then read 0x05 next cycle -> rdata 0xA5A5A5A5.
REQ-040 Reset mid-read: assert rst one cycle after read accepted -> no rsp_valid, all outputs at reset values.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared constants and types for the SRAM port-0 arbiter.
package sram_arb_pkg;

    // Default geometry of the shared SRAM port.
    localparam int DEF_NUM_REQ    = 2;
    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_NUM_WMASKS = 4;

    // Edges from command acceptance to read data being registered.
    localparam int READ_LAT = 2;

    // Kind of SRAM access carried by a command.
    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } sram_op_e;

    // Width of a requester index; a single requester still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sram_port_arb_rr_arbiter.sv
// Round-robin arbiter: combinational grant from valid bits and a registered
// pointer that remembers the last requester served.
module rr_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] i_req_valid,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_grant_idx,
    output logic               o_grant_any
);

    localparam logic [IDX_W:0]   NUM_REQ_W  = (IDX_W + 1)'(NUM_REQ);
    localparam logic [IDX_W-1:0] PTR_RESET  = IDX_W'(NUM_REQ - 1);

    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_idx;
    logic             w_found;
    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_cand;

    // Scan requesters starting one past the last grant and pick the first valid one.
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        w_sum   = '0;
        w_cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_sum   = {1'b0, r_ptr} + (IDX_W + 1)'(k);
            w_sum   = (w_sum >= NUM_REQ_W) ? (w_sum - NUM_REQ_W) : w_sum;
            w_cand  = w_sum[IDX_W-1:0];
            w_idx   = (!w_found && i_req_valid[w_cand]) ? w_cand : w_idx;
            w_found = w_found | i_req_valid[w_cand];
        end
    end

    // Drive the one-hot grant; nothing is granted while reset is held.
    always_comb begin
        o_grant     = '0;
        o_grant_any = 1'b0;
        o_grant_idx = w_idx;
        if (rst) begin
            o_grant     = '0;
            o_grant_any = 1'b0;
        end else begin
            o_grant[w_idx] = w_found;
            o_grant_any    = w_found;
        end
    end

    // Remember the requester just served; the pointer only moves on acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= PTR_RESET;
        end else if (o_grant_any) begin
            r_ptr <= w_idx;
        end else begin
            r_ptr <= r_ptr;
        end
    end

endmodule

// File: rtl/sram_port_arb.sv
// Arbitrates several requesters onto SRAM port 0, registers the SRAM control
// signals, and routes read data back to the issuing requester.
module sram_port_arb
    import sram_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_WMASKS = DEF_NUM_WMASKS
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ-1:0]               req_we,
    input  logic [NUM_REQ*NUM_WMASKS-1:0]    req_wmask,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic                             sram_csb0,
    output logic                             sram_web0,
    output logic [NUM_WMASKS-1:0]            sram_wmask0,
    output logic [ADDR_WIDTH-1:0]            sram_addr0,
    output logic [DATA_WIDTH-1:0]            sram_din0,
    input  logic [DATA_WIDTH-1:0]            sram_dout0
);

    localparam int IDX_W = idx_width(NUM_REQ);

    logic [NUM_REQ-1:0]    w_grant;
    logic [IDX_W-1:0]      w_grant_idx;
    logic                  w_grant_any;

    sram_op_e              w_sel_op;
    logic [NUM_WMASKS-1:0] w_sel_wmask;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;
    logic                  w_new_rd;

    logic                  r_csb;
    logic                  r_web;
    logic [NUM_WMASKS-1:0] r_wmask;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_din;

    logic                  r_rd_vld [READ_LAT];
    logic [IDX_W-1:0]      r_rd_idx [READ_LAT];
    logic [NUM_REQ-1:0]    w_rsp_onehot;
    logic [NUM_REQ-1:0]    r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .clk         (clk),
        .rst         (rst),
        .i_req_valid (req_valid),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_grant_any (w_grant_any)
    );

    // A grant is an acceptance because ready is only raised for a valid requester.
    assign req_ready = w_grant;

    // Select the command fields of the granted requester.
    always_comb begin
        w_sel_op    = OP_READ;
        w_sel_wmask = '0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_sel_op    = (w_grant_idx == IDX_W'(i)) ? sram_op_e'(req_we[i]) : w_sel_op;
            w_sel_wmask = (w_grant_idx == IDX_W'(i)) ? req_wmask[i*NUM_WMASKS +: NUM_WMASKS] : w_sel_wmask;
            w_sel_addr  = (w_grant_idx == IDX_W'(i)) ? req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] : w_sel_addr;
            w_sel_wdata = (w_grant_idx == IDX_W'(i)) ? req_wdata[i*DATA_WIDTH +: DATA_WIDTH] : w_sel_wdata;
        end
        w_new_rd = w_grant_any && (w_sel_op == OP_READ);
    end

    // Register the SRAM port controls; address and data hold when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_csb   <= 1'b1;
            r_web   <= 1'b1;
            r_wmask <= '0;
            r_addr  <= '0;
            r_din   <= '0;
        end else if (w_grant_any) begin
            r_csb   <= 1'b0;
            r_web   <= (w_sel_op == OP_WRITE) ? 1'b0 : 1'b1;
            r_wmask <= (w_sel_op == OP_WRITE) ? w_sel_wmask : '0;
            r_addr  <= w_sel_addr;
            r_din   <= w_sel_wdata;
        end else begin
            r_csb   <= 1'b1;
            r_web   <= 1'b1;
            r_wmask <= '0;
            r_addr  <= r_addr;
            r_din   <= r_din;
        end
    end

    assign sram_csb0   = r_csb;
    assign sram_web0   = r_web;
    assign sram_wmask0 = r_wmask;
    assign sram_addr0  = r_addr;
    assign sram_din0   = r_din;

    // Track outstanding reads so each response returns to its issuer in order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < READ_LAT; s++) begin
                r_rd_vld[s] <= 1'b0;
                r_rd_idx[s] <= '0;
            end
        end else begin
            r_rd_vld[0] <= w_new_rd;
            r_rd_idx[0] <= w_grant_idx;
            for (int s = 1; s < READ_LAT; s++) begin
                r_rd_vld[s] <= r_rd_vld[s-1];
                r_rd_idx[s] <= r_rd_idx[s-1];
            end
        end
    end

    // Decode the oldest tracked read into a per-requester strobe.
    always_comb begin
        w_rsp_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_rsp_onehot[i] = r_rd_vld[READ_LAT-1] && (r_rd_idx[READ_LAT-1] == IDX_W'(i));
        end
    end

    // Capture SRAM read data together with its strobe; data holds between reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
        end else if (r_rd_vld[READ_LAT-1]) begin
            r_rsp_valid <= w_rsp_onehot;
            r_rsp_rdata <= sram_dout0;
        end else begin
            r_rsp_valid <= '0;
            r_rsp_rdata <= r_rsp_rdata;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_sram_port_arb.sv
// Self-checking bench for sram_port_arb with a behavioural SRAM and a
// transaction-level reference model (round-robin choice, in-order memory).
module tb_sram_port_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  tb_valid, tb_we, req_ready, rsp_valid;
    logic [7:0]  tb_wmask;
    logic [15:0] tb_addr;
    logic [63:0] tb_wdata;
    logic [31:0] rsp_rdata, sram_din0, sram_dout0;
    logic        sram_csb0, sram_web0;
    logic [3:0]  sram_wmask0;
    logic [7:0]  sram_addr0;

    sram_port_arb dut (
        .clk(clk), .rst(rst),
        .req_valid(tb_valid), .req_ready(req_ready), .req_we(tb_we),
        .req_wmask(tb_wmask), .req_addr(tb_addr), .req_wdata(tb_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
        .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input logic [7:0] a);
        return {a, ~a, a ^ 8'h5A, 8'hC3};
    endfunction

    // Behavioural SRAM: inputs sampled on posedge, write/read performed on negedge.
    logic [31:0] sram_mem [256];
    logic        mem_init;
    logic        s_en, s_we;
    logic [7:0]  s_addr;
    logic [3:0]  s_mask;
    logic [31:0] s_din;

    always @(posedge clk) begin
        s_en   <= !sram_csb0;
        s_we   <= !sram_web0;
        s_addr <= sram_addr0;
        s_mask <= sram_wmask0;
        s_din  <= sram_din0;
    end

    always @(negedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) sram_mem[i] <= init_val(i[7:0]);
            sram_dout0 <= 32'h0;
        end else if (s_en && s_we) begin
            for (int b = 0; b < 4; b++)
                if (s_mask[b]) sram_mem[s_addr][b*8 +: 8] <= s_din[b*8 +: 8];
        end else if (s_en) begin
            sram_dout0 <= sram_mem[s_addr];
        end
    end

    // Reference model state
    typedef struct { int due; int idx; logic [31:0] data; } rsp_t;
    rsp_t        rspq[$];
    logic [31:0] ref_mem [256];
    int          last_g;
    logic [7:0]  prev_addr;
    logic [31:0] prev_din;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    logic [31:0] last_rsp_data;
    int          last_rsp_idx;

    task automatic model_reset();
        last_g    = 1;
        rspq.delete();
        prev_addr = 8'h0;
        prev_din  = 32'h0;
    endtask

    task automatic clear_reqs();
        tb_valid = 2'b00; tb_we = 2'b00; tb_wmask = 8'h00;
        tb_addr = 16'h0000; tb_wdata = 64'h0;
    endtask

    task automatic set_req(input int i, input logic v, input logic we, input logic [3:0] m,
                           input logic [7:0] a, input logic [31:0] d);
        tb_valid[i] = v;
        tb_we[i] = we;
        tb_wmask[i*4 +: 4] = m;
        tb_addr[i*8 +: 8] = a;
        tb_wdata[i*32 +: 32] = d;
    endtask

    // One clock of traffic: predict grant, let the edge pass, check port and responses.
    task automatic step();
        int g;
        logic [1:0]  exp_ready, exp_rv;
        logic [7:0]  a;
        logic [31:0] d, exp_rd;
        logic [3:0]  m;
        logic        w;
        logic [45:0] exp_port, got_port;
        rsp_t        r;
        #1;
        g = -1;
        for (int k = 1; k <= 2; k++) begin
            int c;
            c = (last_g + k) % 2;
            if (g < 0 && tb_valid[c]) g = c;
        end
        exp_ready = 2'b00;
        if (g >= 0) exp_ready[g] = 1'b1;
        total++;
        if (req_ready !== exp_ready) begin
            bad++;
            $display("FAIL ready cyc=%0d got=%b exp=%b", cyc, req_ready, exp_ready);
        end
        a = 8'h0; d = 32'h0; m = 4'h0; w = 1'b0;
        if (g >= 0) begin
            a = tb_addr[g*8 +: 8]; d = tb_wdata[g*32 +: 32];
            m = tb_wmask[g*4 +: 4]; w = tb_we[g];
        end
        @(posedge clk); #1;
        cyc++;
        if (g >= 0) begin
            last_g = g;
            prev_addr = a;
            prev_din = d;
            if (w) begin
                for (int b = 0; b < 4; b++) if (m[b]) ref_mem[a][b*8 +: 8] = d[b*8 +: 8];
                exp_port = {1'b0, 1'b0, m, a, d};
            end else begin
                rspq.push_back('{due: cyc + 2, idx: g, data: ref_mem[a]});
                exp_port = {1'b0, 1'b1, 4'h0, a, d};
            end
        end else begin
            exp_port = {1'b1, 1'b1, 4'h0, prev_addr, prev_din};
        end
        got_port = {sram_csb0, sram_web0, sram_wmask0, sram_addr0, sram_din0};
        total++;
        if (got_port !== exp_port) begin
            bad++;
            $display("FAIL sram_port cyc=%0d got=%h exp=%h", cyc, got_port, exp_port);
        end
        exp_rv = 2'b00; exp_rd = 32'h0;
        if (rspq.size() > 0 && rspq[0].due == cyc) begin
            r = rspq.pop_front();
            exp_rv[r.idx] = 1'b1;
            exp_rd = r.data;
            last_rsp_idx = r.idx;
        end
        total++;
        if (rsp_valid !== exp_rv) begin
            bad++;
            $display("FAIL rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, exp_rv);
        end
        if (exp_rv != 2'b00) begin
            last_rsp_data = rsp_rdata;
            total++;
            if (rsp_rdata !== exp_rd) begin
                bad++;
                $display("FAIL rsp_rdata cyc=%0d got=%h exp=%h", cyc, rsp_rdata, exp_rd);
            end
        end
    endtask

    task automatic drain(input int n);
        clear_reqs();
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        logic [81:0] got;
        tb_valid = 2'b11;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            got = {req_ready, rsp_valid, rsp_rdata, sram_csb0, sram_web0, sram_wmask0, sram_addr0, sram_din0};
            total++;
            if (got !== {2'b00, 2'b00, 32'h0, 1'b1, 1'b1, 4'h0, 8'h00, 32'h0}) begin
                bad++;
                $display("FAIL reset_values got=%h", got);
            end
        end
        mem_init = 1'b0;
        rst = 1'b0;
        model_reset();
        // Both requesting right after reset: requester 0 must win on the first edge.
        set_req(0, 1'b1, 1'b0, 4'h0, 8'h01, 32'h0);
        set_req(1, 1'b1, 1'b0, 4'h0, 8'h02, 32'h0);
        step();
        clear_reqs();
        drain(3);
    endtask

    task automatic test_single_read();
        clear_reqs();
        set_req(0, 1'b1, 1'b1, 4'hF, 8'h10, 32'hDEADBEEF);
        step();
        drain(2);
        last_rsp_data = 32'h0;
        set_req(0, 1'b1, 1'b0, 4'h0, 8'h10, 32'h0);
        step();
        drain(3);
        total++;
        if (last_rsp_data !== 32'hDEADBEEF || last_rsp_idx != 0) begin
            bad++;
            $display("FAIL single_read got=%h idx=%0d exp=deadbeef idx=0", last_rsp_data, last_rsp_idx);
        end
    endtask

    task automatic test_contention();
        for (int i = 0; i < 8; i++) begin
            set_req(0, 1'b1, 1'b0, 4'h0, 8'($urandom_range(0, 255)), 32'h0);
            set_req(1, 1'b1, 1'b0, 4'h0, 8'($urandom_range(0, 255)), 32'h0);
            step();
        end
        drain(3);
    endtask

    task automatic test_masked_write();
        clear_reqs();
        set_req(1, 1'b1, 1'b1, 4'hF, 8'h20, 32'hFFFFFFFF);
        step();
        set_req(1, 1'b1, 1'b1, 4'b0101, 8'h20, 32'h11223344);
        step();
        last_rsp_data = 32'h0;
        set_req(1, 1'b1, 1'b0, 4'h0, 8'h20, 32'h0);
        step();
        drain(3);
        total++;
        if (last_rsp_data !== 32'hFF22FF44 || last_rsp_idx != 1) begin
            bad++;
            $display("FAIL masked_write got=%h idx=%0d exp=ff22ff44 idx=1", last_rsp_data, last_rsp_idx);
        end
    endtask

    task automatic test_raw();
        clear_reqs();
        set_req(0, 1'b1, 1'b1, 4'hF, 8'h05, 32'hA5A5A5A5);
        step();
        last_rsp_data = 32'h0;
        set_req(0, 1'b1, 1'b0, 4'h0, 8'h05, 32'h0);
        step();
        drain(3);
        total++;
        if (last_rsp_data !== 32'hA5A5A5A5) begin
            bad++;
            $display("FAIL raw got=%h exp=a5a5a5a5", last_rsp_data);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++) begin
            for (int r = 0; r < 2; r++)
                set_req(r, 1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                        8'($urandom_range(0, 7)), $urandom);
            step();
        end
        drain(3);
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            for (int r = 0; r < 2; r++)
                set_req(r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        4'($urandom_range(0, 15)), 8'($urandom_range(0, 15)), $urandom);
            step();
        end
        drain(4);
    endtask

    task automatic test_reset_mid_read();
        logic [81:0] got;
        clear_reqs();
        set_req(1, 1'b1, 1'b0, 4'h0, 8'h03, 32'h0);
        step();
        rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            got = {req_ready, rsp_valid, rsp_rdata, sram_csb0, sram_web0, sram_wmask0, sram_addr0, sram_din0};
            total++;
            if (got !== {2'b00, 2'b00, 32'h0, 1'b1, 1'b1, 4'h0, 8'h00, 32'h0}) begin
                bad++;
                $display("FAIL mid_reset_values got=%h", got);
            end
            @(posedge clk); #1;
        end
        rst = 1'b0;
        model_reset();
        drain(4);
        set_req(0, 1'b1, 1'b0, 4'h0, 8'h07, 32'h0);
        set_req(1, 1'b1, 1'b0, 4'h0, 8'h08, 32'h0);
        step();
        drain(3);
    endtask

    initial begin
        rst = 1'b1;
        mem_init = 1'b1;
        clear_reqs();
        last_rsp_data = 32'h0;
        last_rsp_idx = -1;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i[7:0]);
        model_reset();
        test_reset();
        test_single_read();
        test_contention();
        test_masked_write();
        test_raw();
        test_back_to_back();
        test_random();
        test_reset_mid_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
